player_objects: RTL and testbench



---
 rtl/video_pkg.sv | 27 ++
 rtl/player_object.sv | 69 ++++++
 rtl/player_objects.sv | 97 +++++++++
 tb/tb_player_objects.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the player-object compositor: register map, CTRL and
// collision bit positions, colour width and the per-player FSM state type.
package video_pkg;

   localparam logic [2:0] REG_GRP0  = 3'd0;
   localparam logic [2:0] REG_GRP1  = 3'd1;
   localparam logic [2:0] REG_POS0  = 3'd2;
   localparam logic [2:0] REG_POS1  = 3'd3;
   localparam logic [2:0] REG_COLP0 = 3'd4;
   localparam logic [2:0] REG_COLP1 = 3'd5;
   localparam logic [2:0] REG_CTRL  = 3'd6;
   localparam logic [2:0] REG_CXCLR = 3'd7;

   localparam int CTRL_REFP0 = 0;
   localparam int CTRL_REFP1 = 1;
   localparam int CTRL_PFPRI = 2;

   localparam int CX_P0P1 = 0;
   localparam int CX_P0PF = 1;
   localparam int CX_P1PF = 2;

   localparam int COLOR_W = 7;
   typedef logic [COLOR_W-1:0] color_t;

   typedef enum logic {P_IDLE, P_DRAW} player_state_e;

endpackage

// File: rtl/player_object.sv
// One 8-bit player sprite: waits for its start column, then shifts GRP out
// MSB-first, each bit stretched over 2**PLAYER_SHIFT pixels.
module player_object
   import video_pkg::*;
#(
   parameter int PLAYER_SHIFT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] grp,
   input  logic [7:0] pos,
   input  logic       reflect,
   input  logic [9:0] hpos,
   input  logic       in_image,
   output logic       pixel
);

   player_state_e           state_q;
   logic [7:0]              sr_q;
   logic [2:0]              bit_q;
   logic [PLAYER_SHIFT-1:0] sub_q;

   logic [7:0]              load;
   logic                    trigger;
   logic [7:0]              sr_src;
   logic [2:0]              bit_src;
   logic [PLAYER_SHIFT-1:0] sub_src;
   logic                    sub_wrap;
   logic                    last_pix;

   // The entry pixel is shown straight from the freshly loaded pattern with
   // cleared counters, so the registers always hold the state of the next pixel.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         load[i] = reflect ? grp[7-i] : grp[i];
      end
      trigger  = (state_q == P_IDLE) && in_image && (hpos == {pos, 2'b00});
      sr_src   = trigger ? load : sr_q;
      bit_src  = trigger ? 3'd0 : bit_q;
      sub_src  = trigger ? '0 : sub_q;
      sub_wrap = &sub_src;
      last_pix = sub_wrap && (&bit_src);
      pixel    = in_image && (trigger || (state_q == P_DRAW)) && sr_src[7];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= P_IDLE;
         sr_q    <= 8'd0;
         bit_q   <= 3'd0;
         sub_q   <= '0;
      end else begin
         if ((state_q == P_DRAW) && !in_image) begin
            state_q <= P_IDLE;
         end else if (trigger || (state_q == P_DRAW)) begin
            state_q <= last_pix ? P_IDLE : P_DRAW;
            sub_q   <= sub_src + 1'b1;
            if (sub_wrap) begin
               sr_q  <= {sr_src[6:0], 1'b0};
               bit_q <= bit_src + 3'd1;
            end else begin
               sr_q  <= sr_src;
               bit_q <= bit_src;
            end
         end
      end
   end

endmodule

// File: rtl/player_objects.sv
// Register file, two player sprites, priority compositor and sticky collision
// latches feeding the 7-bit colour index to the hdmi encoder.
module player_objects
   import video_pkg::*;
#(
   parameter int PLAYER_SHIFT = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               write_enable,
   input  logic [2:0]         address,
   input  logic [7:0]         data_in,
   input  logic [9:0]         hpos,
   input  logic               in_image,
   input  logic               playfield_on,
   input  logic [COLOR_W-1:0] color_fg,
   input  logic [COLOR_W-1:0] color_bg,
   output logic [COLOR_W-1:0] color,
   output logic [2:0]         collision
);

   logic [7:0] grp0_q, grp1_q, pos0_q, pos1_q;
   color_t     colp0_q, colp1_q;
   logic [2:0] ctrl_q;
   color_t     color_q, color_d;
   logic [2:0] collision_q, collision_d;
   logic       p0, p1;
   logic       cxclr;

   always_ff @(posedge clk) begin
      if (reset) begin
         grp0_q  <= 8'd0;
         grp1_q  <= 8'd0;
         pos0_q  <= 8'd0;
         pos1_q  <= 8'd0;
         colp0_q <= '0;
         colp1_q <= '0;
         ctrl_q  <= 3'd0;
      end else if (write_enable) begin
         case (address)
            REG_GRP0:  grp0_q  <= data_in;
            REG_GRP1:  grp1_q  <= data_in;
            REG_POS0:  pos0_q  <= data_in;
            REG_POS1:  pos1_q  <= data_in;
            REG_COLP0: colp0_q <= data_in[7:1];
            REG_COLP1: colp1_q <= data_in[7:1];
            REG_CTRL:  ctrl_q  <= data_in[2:0];
            default:   ;
         endcase
      end
   end

   player_object #(.PLAYER_SHIFT(PLAYER_SHIFT)) u_p0 (
      .clk(clk), .reset(reset), .grp(grp0_q), .pos(pos0_q),
      .reflect(ctrl_q[CTRL_REFP0]), .hpos(hpos), .in_image(in_image), .pixel(p0)
   );

   player_object #(.PLAYER_SHIFT(PLAYER_SHIFT)) u_p1 (
      .clk(clk), .reset(reset), .grp(grp1_q), .pos(pos1_q),
      .reflect(ctrl_q[CTRL_REFP1]), .hpos(hpos), .in_image(in_image), .pixel(p1)
   );

   // Player pixels are already gated by in_image, so collisions only arise
   // inside the picture; a CXCLR write discards the same cycle's new hits.
   always_comb begin
      cxclr   = write_enable && (address == REG_CXCLR);
      color_d = '0;
      if (in_image) begin
         if (ctrl_q[CTRL_PFPRI]) begin
            color_d = playfield_on ? color_fg : p0 ? colp0_q : p1 ? colp1_q : color_bg;
         end else begin
            color_d = p0 ? colp0_q : p1 ? colp1_q : playfield_on ? color_fg : color_bg;
         end
      end
      collision_d          = collision_q;
      collision_d[CX_P0P1] = collision_q[CX_P0P1] | (p0 & p1);
      collision_d[CX_P0PF] = collision_q[CX_P0PF] | (p0 & playfield_on);
      collision_d[CX_P1PF] = collision_q[CX_P1PF] | (p1 & playfield_on);
      if (cxclr) begin
         collision_d = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         color_q     <= '0;
         collision_q <= 3'd0;
      end else begin
         color_q     <= color_d;
         collision_q <= collision_d;
      end
   end

   assign color     = color_q;
   assign collision = collision_q;

endmodule

// File: tb/tb_player_objects.sv
// Self-checking bench: a per-pixel behavioural model of sprites, priority and
// collisions is compared every cycle, plus literal expectations per scenario.
module tb_player_objects;

   logic       clk = 1'b0;
   logic       reset, write_enable, in_image, playfield_on;
   logic [2:0] address;
   logic [7:0] data_in;
   logic [9:0] hpos;
   logic [6:0] color_fg, color_bg, color;
   logic [2:0] collision;

   int checks = 0;
   int failures = 0;
   int printed = 0;

   player_objects dut (
      .clk(clk), .reset(reset), .write_enable(write_enable), .address(address),
      .data_in(data_in), .hpos(hpos), .in_image(in_image), .playfield_on(playfield_on),
      .color_fg(color_fg), .color_bg(color_bg), .color(color), .collision(collision)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [7:0] mGrp [2];
   logic [7:0] mPos [2];
   logic [6:0] mColp [2];
   logic [2:0] mCtrl;
   logic [2:0] mColl;
   bit         mActive [2];
   int         mK [2];
   logic [7:0] mSnap [2];
   bit         mRef [2];
   bit         mPix [2];
   logic [6:0] expColor;
   logic [2:0] expColl;
   int         lastH;
   bit         started = 0;
   int         bitIdx;

   logic [6:0] lineColor [0:1023];
   logic [2:0] lineColl [0:1023];

   // The model works pixel by pixel: an active player is k pixels into its
   // 32-pixel span and shows pattern bit k/4 (counted from the MSB unless reflected).
   always @(posedge clk) begin
      lastH = int'(hpos);
      started = 1;
      if (reset) begin
         for (int n = 0; n < 2; n++) begin
            mGrp[n] = 0; mPos[n] = 0; mColp[n] = 0; mActive[n] = 0; mK[n] = 0;
         end
         mCtrl = 0; mColl = 0; expColor = 0; expColl = 0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            mPix[n] = 0;
            if (mActive[n] && !in_image) mActive[n] = 0;
            if (!mActive[n] && in_image && (int'(hpos) == int'(mPos[n]) * 4)) begin
               mActive[n] = 1; mK[n] = 0; mSnap[n] = mGrp[n]; mRef[n] = mCtrl[n];
            end
            if (mActive[n]) begin
               bitIdx = mK[n] / 4;
               mPix[n] = mRef[n] ? mSnap[n][bitIdx] : mSnap[n][7-bitIdx];
               mK[n]++;
               if (mK[n] == 32) mActive[n] = 0;
            end
         end
         if (!in_image) expColor = 0;
         else if (mCtrl[2])
            expColor = playfield_on ? color_fg : mPix[0] ? mColp[0] : mPix[1] ? mColp[1] : color_bg;
         else
            expColor = mPix[0] ? mColp[0] : mPix[1] ? mColp[1] : playfield_on ? color_fg : color_bg;
         if (in_image) begin
            if (mPix[0] && mPix[1]) mColl[0] = 1;
            if (mPix[0] && playfield_on) mColl[1] = 1;
            if (mPix[1] && playfield_on) mColl[2] = 1;
         end
         if (write_enable) begin
            case (address)
               3'd0: mGrp[0] = data_in;
               3'd1: mGrp[1] = data_in;
               3'd2: mPos[0] = data_in;
               3'd3: mPos[1] = data_in;
               3'd4: mColp[0] = data_in[7:1];
               3'd5: mColp[1] = data_in[7:1];
               3'd6: mCtrl = data_in[2:0];
               default: mColl = 0;
            endcase
         end
         expColl = mColl;
      end
   end

   // Per-cycle compare against the model, and capture per column for literal checks
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (color !== expColor) begin
            failures++;
            if (printed < 30) begin
               printed++;
               $display("[TB] FAIL color h=%0d got=%h exp=%h", lastH, color, expColor);
            end
         end
         checks++;
         if (collision !== expColl) begin
            failures++;
            if (printed < 30) begin
               printed++;
               $display("[TB] FAIL collision h=%0d got=%b exp=%b", lastH, collision, expColl);
            end
         end
         if (lastH >= 0 && lastH < 1024) begin
            lineColor[lastH] = color;
            lineColl[lastH] = collision;
         end
      end
   end

   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      write_enable = 1; address = a; data_in = d;
      @(negedge clk);
      write_enable = 0;
   endtask

   // One 800-column line, 720 visible; optional write and reset at given columns
   task automatic applyStimulus(input int pfMode, input int wrCol, input logic [2:0] wrA,
                                input logic [7:0] wrD, input int rstCol);
      for (int h = 0; h < 800; h++) begin
         @(negedge clk);
         hpos = 10'(h);
         in_image = (h < 720);
         playfield_on = (pfMode == 1) ? 1'b1 : (pfMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         write_enable = (h == wrCol);
         address = wrA;
         data_in = wrD;
         reset = (h == rstCol);
      end
      @(negedge clk);
      write_enable = 0; reset = 0; in_image = 0;
   endtask

   int cnt;

   initial begin
      reset = 1; write_enable = 0; address = 0; data_in = 0; hpos = 10'd799;
      in_image = 0; playfield_on = 0; color_fg = 7'h55; color_bg = 7'h01;
      repeat (3) @(negedge clk);
      checkOutput("reset_color", int'(color), 0);
      checkOutput("reset_collision", int'(collision), 0);
      reset = 0;

      // Single leading bit at column 40
      writeReg(3'd0, 8'h80); writeReg(3'd2, 8'd10); writeReg(3'd4, 8'h44);
      applyStimulus(0, -1, 3'd0, 8'h00, -1);
      checkOutput("p0_col40", int'(lineColor[40]), 'h22);
      checkOutput("p0_col43", int'(lineColor[43]), 'h22);
      checkOutput("p0_col39", int'(lineColor[39]), 'h01);
      checkOutput("p0_col44", int'(lineColor[44]), 'h01);

      // Reflect moves the single low bit to the front of the span
      writeReg(3'd0, 8'h01); writeReg(3'd2, 8'd0); writeReg(3'd6, 8'h01);
      applyStimulus(0, -1, 3'd0, 8'h00, -1);
      checkOutput("refl_col0", int'(lineColor[0]), 'h22);
      checkOutput("refl_col3", int'(lineColor[3]), 'h22);
      checkOutput("refl_col28", int'(lineColor[28]), 'h01);
      writeReg(3'd6, 8'h00);
      applyStimulus(0, -1, 3'd0, 8'h00, -1);
      checkOutput("norm_col0", int'(lineColor[0]), 'h01);
      checkOutput("norm_col28", int'(lineColor[28]), 'h22);
      checkOutput("norm_col31", int'(lineColor[31]), 'h22);

      // Overlapping players, P0 wins, P0&P1 collision only
      writeReg(3'd0, 8'hFF); writeReg(3'd1, 8'hFF); writeReg(3'd2, 8'd20);
      writeReg(3'd3, 8'd20); writeReg(3'd5, 8'h66);
      applyStimulus(0, -1, 3'd0, 8'h00, -1);
      checkOutput("ovl_col80", int'(lineColor[80]), 'h22);
      checkOutput("ovl_col111", int'(lineColor[111]), 'h22);
      checkOutput("ovl_col112", int'(lineColor[112]), 'h01);
      checkOutput("ovl_coll", int'(collision), 'b001);
      writeReg(3'd7, 8'h5A);
      checkOutput("cxclr", int'(collision), 0);

      // Playfield priority toggle against P1
      writeReg(3'd0, 8'h00); writeReg(3'd3, 8'd5);
      applyStimulus(1, -1, 3'd0, 8'h00, -1);
      checkOutput("pri0_col20", int'(lineColor[20]), 'h33);
      checkOutput("pri0_col51", int'(lineColor[51]), 'h33);
      checkOutput("pri0_coll", int'(collision), 'b100);
      writeReg(3'd7, 8'h00); writeReg(3'd6, 8'h04);
      applyStimulus(1, -1, 3'd0, 8'h00, -1);
      checkOutput("pri1_col20", int'(lineColor[20]), 'h55);
      checkOutput("pri1_coll", int'(collision), 'b100);
      writeReg(3'd6, 8'h00); writeReg(3'd7, 8'h00);

      // Mid-draw GRP0 write only affects the next line
      writeReg(3'd0, 8'hFF); writeReg(3'd2, 8'd10); writeReg(3'd1, 8'h00);
      applyStimulus(0, 50, 3'd0, 8'h00, -1);
      checkOutput("middraw_col40", int'(lineColor[40]), 'h22);
      checkOutput("middraw_col71", int'(lineColor[71]), 'h22);
      checkOutput("middraw_col72", int'(lineColor[72]), 'h01);
      applyStimulus(0, -1, 3'd0, 8'h00, -1);
      checkOutput("nextline_col40", int'(lineColor[40]), 'h01);

      // Reset in the middle of overlapping draws
      writeReg(3'd0, 8'hFF); writeReg(3'd1, 8'hFF); writeReg(3'd3, 8'd10);
      applyStimulus(0, -1, 3'd0, 8'h00, 50);
      checkOutput("rst_col49", int'(lineColor[49]), 'h22);
      checkOutput("rst_col50", int'(lineColor[50]), 0);
      checkOutput("rst_coll49", int'(lineColl[49]), 'b001);
      checkOutput("rst_coll50", int'(lineColl[50]), 0);
      checkOutput("rst_col51", int'(lineColor[51]), 'h01);

      // Position 180 is off the end of the line
      writeReg(3'd0, 8'hFF); writeReg(3'd2, 8'd180); writeReg(3'd4, 8'h44);
      applyStimulus(0, -1, 3'd0, 8'h00, -1);
      cnt = 0;
      for (int h = 0; h < 720; h++) if (lineColor[h] == 7'h22) cnt++;
      checkOutput("pos180_pixels", cnt, 0);

      // CXCLR on the final overlapping pixel drops that hit and all earlier ones
      writeReg(3'd1, 8'hFF); writeReg(3'd2, 8'd20); writeReg(3'd3, 8'd20);
      applyStimulus(0, 111, 3'd7, 8'h00, -1);
      checkOutput("cxclr_same_cycle", int'(collision), 0);

      // Randomised lines checked cycle by cycle against the model
      for (int l = 0; l < 14; l++) begin
         color_fg = 7'($urandom); color_bg = 7'($urandom);
         for (int r = 0; r < 7; r++) begin
            if (r == 2 || r == 3) writeReg(3'(r), 8'($urandom_range(0, 185)));
            else writeReg(3'(r), 8'($urandom));
         end
         applyStimulus(2, int'($urandom_range(0, 760)), 3'($urandom_range(0, 7)),
                       8'($urandom), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
